// File: rtl/chunk_row_arbiter_pkg.sv
// Project-wide DMA configuration plus shared helpers for the chunk row arbiter.
// TauCfg carries the global widths every DmaPipeline block is sized from.
package TauCfg;
  localparam int GLOBAL_ADDR_BW = 32;
  localparam int DIM            = 2;
  localparam int VSIZE          = 16;
endpackage

package chunk_row_arbiter_pkg;
  // Increment with wrap-around for a ring of n entries.
  function automatic int wrapInc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/chunk_row_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N_REQ.
module RoundRobinPick #(
  parameter int N_REQ = 2,
  parameter int IBW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IBW-1:0]   ptr_i,
  output logic             valid_o,
  output logic [IBW-1:0]   idx_o
);

  logic [IBW:0] cand;

  // Scan from the farthest offset down so the closest requester to ptr wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_i} + (IBW+1)'(i);
      if (cand >= (IBW+1)'(N_REQ)) begin
        cand = cand - (IBW+1)'(N_REQ);
      end
      if (req_i[cand[IBW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[IBW-1:0];
      end
    end
  end

endmodule

// File: rtl/chunk_row_arbiter.sv
// Shares one ChunkRowStart generator between N_REQ chunk requesters, holding
// the grant until the chunk's last row is handed off.
module chunk_row_arbiter
  import chunk_row_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int GBW   = TauCfg::GLOBAL_ADDR_BW,
  parameter int DIM   = TauCfg::DIM,
  parameter int V_BW  = $clog2(TauCfg::VSIZE),
  parameter int IBW   = $clog2(N_REQ)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [N_REQ-1:0]                      req_rdy,
  output logic [N_REQ-1:0]                      req_ack,
  input  logic [N_REQ-1:0][DIM-1:0][GBW-1:0]    i_req_mofs,
  input  logic [N_REQ-1:0][DIM-1:0][V_BW-1:0]   i_req_mpad,
  input  logic [N_REQ-1:0][DIM-1:0][GBW-1:0]    i_req_mbound,
  input  logic [N_REQ-1:0][DIM-1:0][GBW-1:0]    i_req_mlast,
  input  logic [N_REQ-1:0][GBW-1:0]             i_req_maddr,
  input  logic [N_REQ-1:0]                      i_req_wrap,
  output logic                                  mofs_rdy,
  input  logic                                  mofs_ack,
  output logic [DIM-1:0][GBW-1:0]               o_mofs,
  output logic [DIM-1:0][V_BW-1:0]              o_mpad,
  output logic [DIM-1:0][GBW-1:0]               o_mbound,
  output logic [DIM-1:0][GBW-1:0]               o_mlast,
  output logic [GBW-1:0]                        o_maddr,
  output logic                                  o_wrap,
  input  logic                                  row_rdy,
  input  logic                                  row_ack,
  input  logic                                  i_row_islast,
  output logic [IBW-1:0]                        o_row_id,
  output logic                                  o_busy,
  output logic [N_REQ-1:0]                      o_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [IBW-1:0]          ptr_q, ptr_d;
  logic [IBW-1:0]          id_q, id_d;
  logic                    load;
  logic                    pickValid;
  logic [IBW-1:0]          pickIdx;
  logic                    lastRowXfer;

  logic [DIM-1:0][GBW-1:0]  mofs_q, mbound_q, mlast_q;
  logic [DIM-1:0][V_BW-1:0] mpad_q;
  logic [GBW-1:0]           maddr_q;
  logic                     wrap_q;

  RoundRobinPick #(.N_REQ(N_REQ), .IBW(IBW)) u_pick (
    .req_i   (req_rdy),
    .ptr_i   (ptr_q),
    .valid_o (pickValid),
    .idx_o   (pickIdx)
  );

  assign lastRowXfer = row_rdy & row_ack & i_row_islast;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    load     = 1'b0;
    req_ack  = '0;
    mofs_rdy = 1'b0;
    o_done   = '0;
    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          req_ack[pickIdx] = 1'b1;
          id_d             = pickIdx;
          load             = 1'b1;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        mofs_rdy = 1'b1;
        if (mofs_ack) state_d = STREAM;
      end
      STREAM: begin
        // Only the last row of the chunk releases the grant; the owner goes to the back.
        if (lastRowXfer) begin
          o_done[id_q] = 1'b1;
          ptr_d        = IBW'(wrapInc(int'(id_q), N_REQ));
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      mofs_q   <= '0;
      mpad_q   <= '0;
      mbound_q <= '0;
      mlast_q  <= '0;
      maddr_q  <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      if (load) begin
        mofs_q   <= i_req_mofs[pickIdx];
        mpad_q   <= i_req_mpad[pickIdx];
        mbound_q <= i_req_mbound[pickIdx];
        mlast_q  <= i_req_mlast[pickIdx];
        maddr_q  <= i_req_maddr[pickIdx];
        wrap_q   <= i_req_wrap[pickIdx];
      end
    end
  end

  assign o_mofs   = mofs_q;
  assign o_mpad   = mpad_q;
  assign o_mbound = mbound_q;
  assign o_mlast  = mlast_q;
  assign o_maddr  = maddr_q;
  assign o_wrap   = wrap_q;
  assign o_row_id = id_q;
  assign o_busy   = (state_q != IDLE);

  // The generator must not emit rows before it has accepted the descriptor.
  a_no_row_in_issue: assert property (@(posedge i_clk) disable iff (i_rst)
    !(state_q == ISSUE && row_rdy && row_ack));

endmodule

// File: tb/tb_chunk_row_arbiter.sv
// Directed self-checking bench for chunk_row_arbiter (N_REQ=2 main instance,
// N_REQ=3 instance for pointer wrap).
module tb_chunk_row_arbiter;

  localparam int GBW  = TauCfg::GLOBAL_ADDR_BW;
  localparam int DIM  = TauCfg::DIM;
  localparam int V_BW = $clog2(TauCfg::VSIZE);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N_REQ = 2 instance
  logic [1:0]                    req_rdy, req_ack;
  logic [1:0][DIM-1:0][GBW-1:0]  req_mofs, req_mbound, req_mlast;
  logic [1:0][DIM-1:0][V_BW-1:0] req_mpad;
  logic [1:0][GBW-1:0]           req_maddr;
  logic [1:0]                    req_wrap;
  logic                          mofs_rdy, mofs_ack;
  logic [DIM-1:0][GBW-1:0]       o_mofs, o_mbound, o_mlast;
  logic [DIM-1:0][V_BW-1:0]      o_mpad;
  logic [GBW-1:0]                o_maddr;
  logic                          o_wrap;
  logic                          row_rdy, row_ack, row_islast;
  logic [0:0]                    row_id;
  logic                          busy;
  logic [1:0]                    done;

  // N_REQ = 3 instance
  logic [2:0]                    req_rdy3, req_ack3;
  logic [2:0][DIM-1:0][GBW-1:0]  req_mofs3, req_mbound3, req_mlast3;
  logic [2:0][DIM-1:0][V_BW-1:0] req_mpad3;
  logic [2:0][GBW-1:0]           req_maddr3;
  logic [2:0]                    req_wrap3;
  logic                          mofs_rdy3, mofs_ack3;
  logic [DIM-1:0][GBW-1:0]       o_mofs3, o_mbound3, o_mlast3;
  logic [DIM-1:0][V_BW-1:0]      o_mpad3;
  logic [GBW-1:0]                o_maddr3;
  logic                          o_wrap3;
  logic                          row_rdy3, row_ack3, row_islast3;
  logic [1:0]                    row_id3;
  logic                          busy3;
  logic [2:0]                    done3;

  chunk_row_arbiter #(.N_REQ(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .req_rdy(req_rdy), .req_ack(req_ack),
    .i_req_mofs(req_mofs), .i_req_mpad(req_mpad), .i_req_mbound(req_mbound),
    .i_req_mlast(req_mlast), .i_req_maddr(req_maddr), .i_req_wrap(req_wrap),
    .mofs_rdy(mofs_rdy), .mofs_ack(mofs_ack),
    .o_mofs(o_mofs), .o_mpad(o_mpad), .o_mbound(o_mbound), .o_mlast(o_mlast),
    .o_maddr(o_maddr), .o_wrap(o_wrap),
    .row_rdy(row_rdy), .row_ack(row_ack), .i_row_islast(row_islast),
    .o_row_id(row_id), .o_busy(busy), .o_done(done)
  );

  chunk_row_arbiter #(.N_REQ(3)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .req_rdy(req_rdy3), .req_ack(req_ack3),
    .i_req_mofs(req_mofs3), .i_req_mpad(req_mpad3), .i_req_mbound(req_mbound3),
    .i_req_mlast(req_mlast3), .i_req_maddr(req_maddr3), .i_req_wrap(req_wrap3),
    .mofs_rdy(mofs_rdy3), .mofs_ack(mofs_ack3),
    .o_mofs(o_mofs3), .o_mpad(o_mpad3), .o_mbound(o_mbound3), .o_mlast(o_mlast3),
    .o_maddr(o_maddr3), .o_wrap(o_wrap3),
    .row_rdy(row_rdy3), .row_ack(row_ack3), .i_row_islast(row_islast3),
    .o_row_id(row_id3), .o_busy(busy3), .o_done(done3)
  );

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setRows(input logic r, input logic a, input logic l);
    row_rdy    = r;
    row_ack    = a;
    row_islast = l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_rdy = '0; req_mofs = '0; req_mpad = '0; req_mbound = '0; req_mlast = '0;
    req_maddr = '0; req_wrap = '0; mofs_ack = 1'b0; setRows(1'b0, 1'b0, 1'b0);
    req_rdy3 = '0; req_mofs3 = '0; req_mpad3 = '0; req_mbound3 = '0; req_mlast3 = '0;
    req_maddr3 = '0; req_wrap3 = '0; mofs_ack3 = 1'b0;
    row_rdy3 = 1'b0; row_ack3 = 1'b0; row_islast3 = 1'b0;
    nextCycle();
    nextCycle();
    checks++;
    if ({mofs_rdy, busy, done, req_ack} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000", {mofs_rdy, busy, done, req_ack});
    end
    checks++;
    if ({o_maddr, o_mofs, o_mpad, o_mbound, o_mlast, o_wrap, row_id} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_desc: got maddr=%h wrap=%b id=%0d expected all zero", o_maddr, o_wrap, row_id);
    end
    checks++;
    if ({mofs_rdy3, busy3, done3, row_id3} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_n3: got %b expected 0000000", {mofs_rdy3, busy3, done3, row_id3});
    end
    rst = 1'b0;
    nextCycle();
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    nextCycle();
  endtask

  task automatic test_single_requester();
    req_maddr[0] = 32'h100;
    req_rdy      = 2'b01;
    mofs_ack     = 1'b1;
    #1;
    checks++;
    if ({req_ack, busy} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL single_ack: got ack=%b busy=%b expected ack=01 busy=0", req_ack, busy);
    end
    nextCycle();
    req_rdy = 2'b00;
    #1;
    checks++;
    if ({mofs_rdy, busy, req_ack} !== 4'b1100 || o_maddr !== 32'h100) begin
      errors++;
      $display("[TB] FAIL single_issue: got rdy=%b busy=%b ack=%b maddr=%h expected 1 1 00 100",
               mofs_rdy, busy, req_ack, o_maddr);
    end
    nextCycle();
    for (int r = 0; r < 3; r++) begin
      setRows(1'b1, 1'b1, r == 2);
      #1;
      checks++;
      if ({busy, done, mofs_rdy} !== ((r == 2) ? 4'b1010 : 4'b1000)) begin
        errors++;
        $display("[TB] FAIL single_row%0d: got busy=%b done=%b rdy=%b", r, busy, done, mofs_rdy);
      end
      nextCycle();
    end
    setRows(1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({busy, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL single_idle: got busy=%b done=%b expected 0 00", busy, done);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] expOh;
    pulseReset();
    req_maddr[0] = 32'h100;
    req_maddr[1] = 32'h200;
    req_rdy      = 2'b11;
    mofs_ack     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expOh = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (req_ack !== expOh) begin
        errors++;
        $display("[TB] FAIL fair_grant%0d: got %b expected %b", k, req_ack, expOh);
      end
      nextCycle();
      checks++;
      if (row_id !== 1'(k % 2) || o_maddr !== ((k % 2 == 0) ? 32'h100 : 32'h200) || mofs_rdy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL fair_issue%0d: got id=%0d maddr=%h rdy=%b", k, row_id, o_maddr, mofs_rdy);
      end
      nextCycle();
      setRows(1'b1, 1'b1, 1'b1);
      #1;
      checks++;
      if (done !== expOh || row_id !== 1'(k % 2)) begin
        errors++;
        $display("[TB] FAIL fair_done%0d: got done=%b id=%0d expected %b %0d", k, done, row_id, expOh, k % 2);
      end
      nextCycle();
      setRows(1'b0, 1'b0, 1'b0);
    end
    req_rdy = 2'b00;
  endtask

  task automatic test_back_pressure();
    req_maddr[1] = 32'h200;
    req_mofs[1]  = {32'h11, 32'h22};
    req_mpad[1]  = {4'h3, 4'h5};
    req_wrap[1]  = 1'b1;
    req_rdy      = 2'b10;
    mofs_ack     = 1'b0;
    #1;
    checks++;
    if (req_ack !== 2'b10) begin
      errors++;
      $display("[TB] FAIL bp_grant: got %b expected 10", req_ack);
    end
    nextCycle();
    // Descriptor may change after ack; requester 0 now waits during ISSUE.
    req_maddr[1] = 32'hDEAD;
    req_wrap[1]  = 1'b0;
    req_rdy      = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({mofs_rdy, busy, req_ack} !== 4'b1100 || o_maddr !== 32'h200 ||
          {o_mofs, o_mpad, o_wrap} !== {32'h11, 32'h22, 4'h3, 4'h5, 1'b1}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got rdy=%b ack=%b maddr=%h mofs=%h wrap=%b",
                 c, mofs_rdy, req_ack, o_maddr, o_mofs, o_wrap);
      end
      nextCycle();
    end
    mofs_ack = 1'b1;
    nextCycle();
    mofs_ack = 1'b0;
  endtask

  task automatic test_non_last_rows();
    for (int r = 0; r < 4; r++) begin
      setRows(1'b1, 1'b1, 1'b0);
      #1;
      checks++;
      if ({busy, done, req_ack, mofs_rdy} !== 6'b100000) begin
        errors++;
        $display("[TB] FAIL nonlast_row%0d: got busy=%b done=%b ack=%b rdy=%b", r, busy, done, req_ack, mofs_rdy);
      end
      nextCycle();
    end
    setRows(1'b1, 1'b0, 1'b1);
    #1;
    checks++;
    if ({busy, done} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL nonlast_stall: got busy=%b done=%b expected 1 00", busy, done);
    end
    nextCycle();
    setRows(1'b1, 1'b1, 1'b1);
    #1;
    checks++;
    if (done !== 2'b10 || row_id !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nonlast_done: got done=%b id=%0d expected 10 1", done, row_id);
    end
    nextCycle();
    setRows(1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({busy, done, req_ack} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL nonlast_regrant: got busy=%b done=%b ack=%b expected 0 00 01", busy, done, req_ack);
    end
    nextCycle();
    req_rdy  = 2'b00;
    mofs_ack = 1'b1;
    nextCycle();
    mofs_ack = 1'b0;
    setRows(1'b1, 1'b1, 1'b1);
    nextCycle();
    setRows(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_stream();
    req_maddr[1] = 32'h200;
    req_wrap[1]  = 1'b1;
    req_rdy      = 2'b10;
    mofs_ack     = 1'b1;
    #1;
    checks++;
    if (req_ack !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rst_pre_grant: got %b expected 10", req_ack);
    end
    nextCycle();
    req_rdy = 2'b00;
    nextCycle();
    checks++;
    if ({busy, row_id} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL rst_pre_stream: got busy=%b id=%0d expected 1 1", busy, row_id);
    end
    setRows(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if ({mofs_rdy, busy, done, row_id, o_wrap} !== 6'b0 || o_maddr !== '0) begin
      errors++;
      $display("[TB] FAIL rst_async: got rdy=%b busy=%b done=%b id=%0d wrap=%b maddr=%h",
               mofs_rdy, busy, done, row_id, o_wrap, o_maddr);
    end
    setRows(1'b0, 1'b0, 1'b0);
    nextCycle();
    rst     = 1'b0;
    req_rdy = 2'b11;
    #1;
    checks++;
    if (req_ack !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rst_ptr_zero: got %b expected 01", req_ack);
    end
    nextCycle();
    req_rdy = 2'b00;
    nextCycle();
    setRows(1'b1, 1'b1, 1'b1);
    nextCycle();
    setRows(1'b0, 1'b0, 1'b0);
    mofs_ack = 1'b0;
  endtask

  task automatic test_wrap_n3();
    req_rdy3  = 3'b100;
    mofs_ack3 = 1'b1;
    #1;
    checks++;
    if (req_ack3 !== 3'b100) begin
      errors++;
      $display("[TB] FAIL wrap_grant2: got %b expected 100", req_ack3);
    end
    nextCycle();
    req_rdy3 = 3'b000;
    #1;
    checks++;
    if ({mofs_rdy3, row_id3} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL wrap_issue: got rdy=%b id=%0d expected 1 2", mofs_rdy3, row_id3);
    end
    nextCycle();
    row_rdy3 = 1'b1; row_ack3 = 1'b1; row_islast3 = 1'b1;
    #1;
    checks++;
    if (done3 !== 3'b100) begin
      errors++;
      $display("[TB] FAIL wrap_done: got %b expected 100", done3);
    end
    nextCycle();
    row_rdy3 = 1'b0; row_ack3 = 1'b0; row_islast3 = 1'b0;
    req_rdy3 = 3'b111;
    #1;
    checks++;
    if (req_ack3 !== 3'b001) begin
      errors++;
      $display("[TB] FAIL wrap_to_zero: got %b expected 001", req_ack3);
    end
    nextCycle();
    nextCycle();
    row_rdy3 = 1'b1; row_ack3 = 1'b1; row_islast3 = 1'b1;
    nextCycle();
    row_rdy3 = 1'b0; row_ack3 = 1'b0; row_islast3 = 1'b0;
    #1;
    checks++;
    if (req_ack3 !== 3'b010) begin
      errors++;
      $display("[TB] FAIL wrap_next1: got %b expected 010", req_ack3);
    end
    req_rdy3  = 3'b000;
    mofs_ack3 = 1'b0;
  endtask

  initial begin
    $display("[TB] chunk_row_arbiter bench start");
    test_reset();
    test_single_requester();
    test_fairness();
    test_back_pressure();
    test_non_last_rows();
    test_reset_mid_stream();
    test_wrap_n3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
